alu_rsv_station: RTL and testbench

- Reservation station for integer/branch/jump ops, directly upstream of the ALU stage.
- Accepts issued instructions from the decoder/issue stage, holding each with operand values or ROB-id tags.
- Snoops the ALU and LSB result broadcasts to wake up waiting operands.
- Each cycle, dispatches at most one fully-ready entry to the ALU as a registered one-cycle pulse.

---
 rtl/alu_rsv_station.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_rsv_station.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_rsv_station.sv
// ALU reservation station: holds issued int/branch/jump ops until both
// operands are known, snoops the ALU/LSB CDBs, dispatches one ready op
// per cycle (lowest index first) as a registered pulse.

// One station slot: storage, bypass-on-insert and CDB wakeup.
module alu_rsv_entry #(
  parameter int ROB_ID_W = 4,
  parameter int OP_W     = 6,
  parameter int DATA_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     ins,
  input  logic                     dsp,
  input  logic [OP_W-1:0]          issue_op_id,
  input  logic [DATA_W-1:0]        issue_pc,
  input  logic [DATA_W-1:0]        issue_imm,
  input  logic [ROB_ID_W-1:0]      issue_rob_id,
  input  logic [1:0]               issue_src_rdy,
  input  logic [1:0][DATA_W-1:0]   issue_src_val,
  input  logic [1:0][ROB_ID_W-1:0] issue_src_tag,
  input  logic                     cdb_alu_valid,
  input  logic [ROB_ID_W-1:0]      cdb_alu_rob_id,
  input  logic [DATA_W-1:0]        cdb_alu_value,
  input  logic                     cdb_lsb_valid,
  input  logic [ROB_ID_W-1:0]      cdb_lsb_rob_id,
  input  logic [DATA_W-1:0]        cdb_lsb_value,
  output logic                     busy,
  output logic                     ready,
  output logic [OP_W-1:0]          op_id,
  output logic [DATA_W-1:0]        pc,
  output logic [DATA_W-1:0]        imm,
  output logic [ROB_ID_W-1:0]      rob_id,
  output logic [1:0][DATA_W-1:0]   src_val
);
  logic [1:0]               src_rdy, s_rdy, n_rdy;
  logic [1:0][ROB_ID_W-1:0] src_tag, s_tag;
  logic [1:0][DATA_W-1:0]   s_val, n_val;

  assign ready = busy && (&src_rdy);

  // Operand source is the issue bus on insert, stored state otherwise;
  // the same CDB match then gives both bypass and wakeup (LSB wins).
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      s_rdy[k] = ins ? issue_src_rdy[k] : src_rdy[k];
      s_val[k] = ins ? issue_src_val[k] : src_val[k];
      s_tag[k] = ins ? issue_src_tag[k] : src_tag[k];
      n_rdy[k] = s_rdy[k];
      n_val[k] = s_val[k];
      if (!s_rdy[k] && cdb_lsb_valid && cdb_lsb_rob_id == s_tag[k]) begin
        n_rdy[k] = 1'b1;
        n_val[k] = cdb_lsb_value;
      end else if (!s_rdy[k] && cdb_alu_valid && cdb_alu_rob_id == s_tag[k]) begin
        n_rdy[k] = 1'b1;
        n_val[k] = cdb_alu_value;
      end
    end
  end

  // Slot state: insert, free on dispatch or flush, capture operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      op_id   <= '0;
      pc      <= '0;
      imm     <= '0;
      rob_id  <= '0;
      src_rdy <= '0;
      src_val <= '0;
      src_tag <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy <= 1'b0;
      end else begin
        if (ins) begin
          busy   <= 1'b1;
          op_id  <= issue_op_id;
          pc     <= issue_pc;
          imm    <= issue_imm;
          rob_id <= issue_rob_id;
        end else if (dsp) begin
          busy <= 1'b0;
        end
        if (ins || busy) begin
          src_rdy <= n_rdy;
          src_val <= n_val;
          src_tag <= s_tag;
        end
      end
    end
  end
endmodule

module alu_rsv_station #(
  parameter int RS_SIZE  = 16,
  parameter int ROB_ID_W = 4,
  parameter int OP_W     = 6,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                issue_valid,
  input  logic [OP_W-1:0]     issue_op_id,
  input  logic [DATA_W-1:0]   issue_pc,
  input  logic [DATA_W-1:0]   issue_imm,
  input  logic [ROB_ID_W-1:0] issue_rob_id,
  input  logic                issue_rs1_rdy,
  input  logic                issue_rs2_rdy,
  input  logic [DATA_W-1:0]   issue_rs1_val,
  input  logic [DATA_W-1:0]   issue_rs2_val,
  input  logic [ROB_ID_W-1:0] issue_rs1_tag,
  input  logic [ROB_ID_W-1:0] issue_rs2_tag,
  output logic                rs_full,
  output logic                alu_valid,
  output logic [OP_W-1:0]     alu_op_id,
  output logic [DATA_W-1:0]   alu_pc,
  output logic [DATA_W-1:0]   alu_rs1,
  output logic [DATA_W-1:0]   alu_rs2,
  output logic [DATA_W-1:0]   alu_imm,
  output logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic                cdb_alu_valid,
  input  logic [ROB_ID_W-1:0] cdb_alu_rob_id,
  input  logic [DATA_W-1:0]   cdb_alu_value,
  input  logic                cdb_lsb_valid,
  input  logic [ROB_ID_W-1:0] cdb_lsb_rob_id,
  input  logic [DATA_W-1:0]   cdb_lsb_value,
  input  logic                roll_back
);
  localparam int CNT_W = $clog2(RS_SIZE) + 1;

  logic [RS_SIZE-1:0]                 busy, ready, ins_oh, dsp_oh;
  logic [RS_SIZE-1:0][OP_W-1:0]       e_op;
  logic [RS_SIZE-1:0][DATA_W-1:0]     e_pc, e_imm;
  logic [RS_SIZE-1:0][ROB_ID_W-1:0]   e_rob;
  logic [RS_SIZE-1:0][1:0][DATA_W-1:0] e_src;
  logic [1:0]                         issue_src_rdy;
  logic [1:0][DATA_W-1:0]             issue_src_val;
  logic [1:0][ROB_ID_W-1:0]           issue_src_tag;
  logic                               ins_found, dsp_found, ins_any, dsp_any;
  logic [OP_W-1:0]                    sel_op;
  logic [DATA_W-1:0]                  sel_pc, sel_imm;
  logic [ROB_ID_W-1:0]                sel_rob;
  logic [1:0][DATA_W-1:0]             sel_src;
  logic [CNT_W-1:0]                   cnt, cnt_next;

  assign issue_src_rdy = {issue_rs2_rdy, issue_rs1_rdy};
  assign issue_src_val = {issue_rs2_val, issue_rs1_val};
  assign issue_src_tag = {issue_rs2_tag, issue_rs1_tag};

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
    alu_rsv_entry #(.ROB_ID_W(ROB_ID_W), .OP_W(OP_W), .DATA_W(DATA_W)) u_ent (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(roll_back),
      .ins(ins_oh[g] && ins_any), .dsp(dsp_oh[g] && dsp_any),
      .issue_op_id(issue_op_id), .issue_pc(issue_pc), .issue_imm(issue_imm),
      .issue_rob_id(issue_rob_id), .issue_src_rdy(issue_src_rdy),
      .issue_src_val(issue_src_val), .issue_src_tag(issue_src_tag),
      .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_id(cdb_alu_rob_id),
      .cdb_alu_value(cdb_alu_value), .cdb_lsb_valid(cdb_lsb_valid),
      .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_value(cdb_lsb_value),
      .busy(busy[g]), .ready(ready[g]), .op_id(e_op[g]), .pc(e_pc[g]),
      .imm(e_imm[g]), .rob_id(e_rob[g]), .src_val(e_src[g])
    );
  end

  // Lowest free slot for insert, lowest ready slot for dispatch, and the
  // post-edge occupancy; all from pre-edge state.
  always_comb begin
    ins_oh    = '0;
    dsp_oh    = '0;
    ins_found = 1'b0;
    dsp_found = 1'b0;
    sel_op    = '0;
    sel_pc    = '0;
    sel_imm   = '0;
    sel_rob   = '0;
    sel_src   = '0;
    cnt       = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!busy[i] && !ins_found) begin
        ins_oh[i] = 1'b1;
        ins_found = 1'b1;
      end
      if (ready[i] && !dsp_found) begin
        dsp_oh[i] = 1'b1;
        dsp_found = 1'b1;
        sel_op    = e_op[i];
        sel_pc    = e_pc[i];
        sel_imm   = e_imm[i];
        sel_rob   = e_rob[i];
        sel_src   = e_src[i];
      end
      cnt = cnt + CNT_W'(busy[i]);
    end
    ins_any  = issue_valid && ins_found && !roll_back;
    dsp_any  = dsp_found && !roll_back;
    cnt_next = cnt + CNT_W'(ins_any) - CNT_W'(dsp_any);
  end

  // Registered dispatch port and backpressure (one slot of slack).
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_valid  <= 1'b0;
      rs_full    <= 1'b0;
      alu_op_id  <= '0;
      alu_pc     <= '0;
      alu_rs1    <= '0;
      alu_rs2    <= '0;
      alu_imm    <= '0;
      alu_rob_id <= '0;
    end else if (rdy) begin
      if (roll_back) begin
        alu_valid <= 1'b0;
        rs_full   <= 1'b0;
      end else begin
        alu_valid <= dsp_found;
        rs_full   <= cnt_next >= CNT_W'(RS_SIZE - 1);
        if (dsp_found) begin
          alu_op_id  <= sel_op;
          alu_pc     <= sel_pc;
          alu_rs1    <= sel_src[0];
          alu_rs2    <= sel_src[1];
          alu_imm    <= sel_imm;
          alu_rob_id <= sel_rob;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_rsv_station.sv
// Bench for alu_rsv_station: directed scenarios plus random traffic, every
// cycle compared against a slot-array reference model.
module tb_alu_rsv_station;
  logic        clk = 1'b0;
  logic        rst, rdy, issue_valid, roll_back;
  logic [5:0]  issue_op_id;
  logic [31:0] issue_pc, issue_imm, issue_rs1_val, issue_rs2_val;
  logic [3:0]  issue_rob_id, issue_rs1_tag, issue_rs2_tag;
  logic        issue_rs1_rdy, issue_rs2_rdy;
  logic        cdb_alu_valid, cdb_lsb_valid;
  logic [3:0]  cdb_alu_rob_id, cdb_lsb_rob_id;
  logic [31:0] cdb_alu_value, cdb_lsb_value;
  logic        rs_full, alu_valid;
  logic [5:0]  alu_op_id;
  logic [31:0] alu_pc, alu_rs1, alu_rs2, alu_imm;
  logic [3:0]  alu_rob_id;

  int n_chk = 0;
  int n_err = 0;

  alu_rsv_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .issue_valid(issue_valid),
    .issue_op_id(issue_op_id), .issue_pc(issue_pc), .issue_imm(issue_imm),
    .issue_rob_id(issue_rob_id), .issue_rs1_rdy(issue_rs1_rdy),
    .issue_rs2_rdy(issue_rs2_rdy), .issue_rs1_val(issue_rs1_val),
    .issue_rs2_val(issue_rs2_val), .issue_rs1_tag(issue_rs1_tag),
    .issue_rs2_tag(issue_rs2_tag), .rs_full(rs_full), .alu_valid(alu_valid),
    .alu_op_id(alu_op_id), .alu_pc(alu_pc), .alu_rs1(alu_rs1),
    .alu_rs2(alu_rs2), .alu_imm(alu_imm), .alu_rob_id(alu_rob_id),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_id(cdb_alu_rob_id),
    .cdb_alu_value(cdb_alu_value), .cdb_lsb_valid(cdb_lsb_valid),
    .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_value(cdb_lsb_value),
    .roll_back(roll_back)
  );

  always #5 clk = ~clk;

  // Reference state: 16 slots, each an instruction record with two operands.
  bit          m_busy [16];
  logic [5:0]  m_op   [16];
  logic [31:0] m_pc   [16];
  logic [31:0] m_imm  [16];
  logic [3:0]  m_rob  [16];
  bit          m_r    [16][2];
  logic [31:0] m_v    [16][2];
  logic [3:0]  m_t    [16][2];
  bit          e_valid = 0, e_full = 0;
  logic [5:0]  e_op = 0;
  logic [31:0] e_pc = 0, e_rs1 = 0, e_rs2 = 0, e_imm = 0;
  logic [3:0]  e_rob = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // An operand waiting on a tag picks up a broadcast this edge; LSB first.
  task automatic wake(input int i, input int k);
    if (!m_r[i][k]) begin
      if (cdb_lsb_valid && cdb_lsb_rob_id == m_t[i][k]) begin
        m_r[i][k] = 1; m_v[i][k] = cdb_lsb_value;
      end else if (cdb_alu_valid && cdb_alu_rob_id == m_t[i][k]) begin
        m_r[i][k] = 1; m_v[i][k] = cdb_alu_value;
      end
    end
  endtask

  task automatic model_edge();
    int d, f, n;
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      e_valid = 0; e_full = 0; e_op = 0; e_pc = 0;
      e_rs1 = 0; e_rs2 = 0; e_imm = 0; e_rob = 0;
      return;
    end
    if (!rdy) return;
    if (roll_back) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      e_valid = 0; e_full = 0;
      return;
    end
    d = -1; f = -1;
    for (int i = 0; i < 16; i++) begin
      if (d < 0 && m_busy[i] && m_r[i][0] && m_r[i][1]) d = i;
      if (f < 0 && !m_busy[i]) f = i;
    end
    e_valid = (d >= 0);
    if (d >= 0) begin
      e_op = m_op[d]; e_pc = m_pc[d]; e_imm = m_imm[d]; e_rob = m_rob[d];
      e_rs1 = m_v[d][0]; e_rs2 = m_v[d][1];
      m_busy[d] = 0;
    end
    for (int i = 0; i < 16; i++)
      if (m_busy[i]) begin wake(i, 0); wake(i, 1); end
    if (issue_valid && f >= 0) begin
      m_busy[f] = 1; m_op[f] = issue_op_id; m_pc[f] = issue_pc;
      m_imm[f] = issue_imm; m_rob[f] = issue_rob_id;
      m_r[f][0] = issue_rs1_rdy; m_v[f][0] = issue_rs1_val; m_t[f][0] = issue_rs1_tag;
      m_r[f][1] = issue_rs2_rdy; m_v[f][1] = issue_rs2_val; m_t[f][1] = issue_rs2_tag;
      wake(f, 0); wake(f, 1);
    end
    n = 0;
    foreach (m_busy[i]) n += m_busy[i];
    e_full = (n >= 15);
  endtask

  task automatic idle();
    rst = 0; rdy = 1; roll_back = 0; issue_valid = 0;
    cdb_alu_valid = 0; cdb_lsb_valid = 0;
  endtask

  task automatic iss(input logic [5:0] op, input logic [31:0] pc, input logic [3:0] rob,
                     input bit r1, input logic [31:0] v1, input logic [3:0] t1,
                     input bit r2, input logic [31:0] v2, input logic [3:0] t2);
    issue_valid = 1; issue_op_id = op; issue_pc = pc; issue_imm = pc ^ 32'h5a5a;
    issue_rob_id = rob;
    issue_rs1_rdy = r1; issue_rs1_val = v1; issue_rs1_tag = t1;
    issue_rs2_rdy = r2; issue_rs2_val = v2; issue_rs2_tag = t2;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("alu_valid", 64'(alu_valid), 64'(e_valid));
    chk("rs_full", 64'(rs_full), 64'(e_full));
    chk("alu_op_id", 64'(alu_op_id), 64'(e_op));
    chk("alu_pc", 64'(alu_pc), 64'(e_pc));
    chk("alu_rs1", 64'(alu_rs1), 64'(e_rs1));
    chk("alu_rs2", 64'(alu_rs2), 64'(e_rs2));
    chk("alu_imm", 64'(alu_imm), 64'(e_imm));
    chk("alu_rob_id", 64'(alu_rob_id), 64'(e_rob));
    idle();
  endtask

  initial begin
    idle();
    issue_op_id = 0; issue_pc = 0; issue_imm = 0; issue_rob_id = 0;
    issue_rs1_rdy = 0; issue_rs2_rdy = 0; issue_rs1_val = 0; issue_rs2_val = 0;
    issue_rs1_tag = 0; issue_rs2_tag = 0;
    cdb_alu_rob_id = 0; cdb_lsb_rob_id = 0; cdb_alu_value = 0; cdb_lsb_value = 0;
    rst = 1; step(); rst = 1; step();

    // ADD, both operands known: dispatched next edge, pulse one cycle
    iss(6'd1, 32'h1000, 4'd3, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0); step();
    step(); chk("add_rs1", 64'(alu_rs1), 64'd5); chk("add_rob", 64'(alu_rob_id), 64'd3);
    step(); chk("add_pulse_end", 64'(alu_valid), 64'd0);

    // ADDI waiting on tag 2, woken by ALU CDB two cycles later
    iss(6'd2, 32'h1004, 4'd4, 0, 32'd0, 4'd2, 1, 32'd0, 4'd0); step();
    step();
    cdb_alu_valid = 1; cdb_alu_rob_id = 4'd2; cdb_alu_value = 32'h100; step();
    step(); chk("wake_rs1", 64'(alu_rs1), 64'h100);
    step();

    // Same-cycle bypass from LSB CDB
    iss(6'd3, 32'h1008, 4'd5, 0, 32'd0, 4'd6, 1, 32'd9, 4'd0);
    cdb_lsb_valid = 1; cdb_lsb_rob_id = 4'd6; cdb_lsb_value = 32'hDEAD; step();
    step(); chk("bypass_rs1", 64'(alu_rs1), 64'hDEAD);
    step();

    // Fill 15 slots waiting on tag 9, then release them in index order
    for (int i = 0; i < 15; i++) begin
      iss(6'(i), 32'h2000 + 32'(4 * i), 4'(i), 0, 32'd0, 4'd9, 1, 32'(i), 4'd0); step();
    end
    chk("full_after_15", 64'(rs_full), 64'd1);
    cdb_alu_valid = 1; cdb_alu_rob_id = 4'd9; cdb_alu_value = 32'h99; step();
    for (int i = 0; i < 16; i++) step();

    // Roll back with four waiting slots and a same-cycle issue
    for (int i = 0; i < 4; i++) begin
      iss(6'd7, 32'h3000 + 32'(i), 4'(i), 0, 32'd0, 4'd11, 1, 32'd0, 4'd0); step();
    end
    iss(6'd8, 32'h3100, 4'd12, 1, 32'd1, 4'd0, 1, 32'd2, 4'd0); roll_back = 1; step();
    cdb_alu_valid = 1; cdb_alu_rob_id = 4'd11; cdb_alu_value = 32'h11; step();
    step(); step();
    iss(6'd9, 32'h3200, 4'd13, 1, 32'd3, 4'd0, 1, 32'd4, 4'd0); step(); step(); step();

    // Freeze: a ready slot and a waiting slot, CDB activity while rdy=0
    iss(6'd10, 32'h4000, 4'd1, 0, 32'd0, 4'd12, 1, 32'd0, 4'd0); step();
    iss(6'd11, 32'h4004, 4'd2, 1, 32'd8, 4'd0, 1, 32'd9, 4'd0); rdy = 0; step();
    for (int i = 0; i < 3; i++) begin
      rdy = 0; cdb_lsb_valid = 1; cdb_lsb_rob_id = 4'd12; cdb_lsb_value = 32'hBAD; step();
    end
    iss(6'd11, 32'h4004, 4'd2, 1, 32'd8, 4'd0, 1, 32'd9, 4'd0); step();
    step();
    cdb_alu_valid = 1; cdb_alu_rob_id = 4'd12; cdb_alu_value = 32'h12; step();
    step(); step();

    // Random traffic within protocol
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      roll_back = ($urandom_range(0, 59) == 0);
      if (!e_full && $urandom_range(0, 1) == 1)
        iss(6'($urandom), $urandom, 4'($urandom),
            $urandom_range(0, 2) != 0, $urandom, 4'($urandom),
            $urandom_range(0, 2) != 0, $urandom, 4'($urandom));
      cdb_alu_valid = ($urandom_range(0, 2) == 0);
      cdb_alu_rob_id = 4'($urandom); cdb_alu_value = $urandom;
      cdb_lsb_valid = ($urandom_range(0, 3) == 0);
      cdb_lsb_rob_id = 4'($urandom); cdb_lsb_value = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
